// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and the frame/oversampling
// defaults that the baud generator and receiver must agree on.
package uart_pkg;

    localparam int DEFAULT_DATA_BITS         = 8;
    localparam int DEFAULT_OVERSAMPLING_RATE = 8;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_HIGH = 3'd4
    } rx_state_t;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for an asynchronous level input; both flops reset to 1
// so an idle-high line never shows a spurious low edge coming out of reset.
module uart_rx_sync (
    input  logic clk_in,
    input  logic nrst_in,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk_in or negedge nrst_in) begin
        if (!nrst_in) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// Oversampling UART receiver: mid-bit sampling of LSB-first frames with one
// stop bit, delivering words through a valid/ready output register.
module uart_rx
    import uart_pkg::*;
#(
    parameter int DATA_BITS         = DEFAULT_DATA_BITS,
    parameter int OVERSAMPLING_RATE = DEFAULT_OVERSAMPLING_RATE
) (
    input  logic                 clk_in,
    input  logic                 nrst_in,
    input  logic                 os_tick_in,
    input  logic                 rx_in,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 valid_out,
    input  logic                 ready_in,
    output logic                 busy_out,
    output logic                 frame_err_out,
    output logic                 overrun_err_out
);

    localparam int TICK_W = $clog2(OVERSAMPLING_RATE);
    localparam int BIT_W  = $clog2(DATA_BITS + 1);

    localparam logic [TICK_W-1:0] HALF_LAST = TICK_W'(OVERSAMPLING_RATE / 2 - 1);
    localparam logic [TICK_W-1:0] BIT_LAST  = TICK_W'(OVERSAMPLING_RATE - 1);
    localparam logic [BIT_W-1:0]  LAST_BIT  = BIT_W'(DATA_BITS - 1);

    logic                 rxs;
    rx_state_t            state;
    logic [TICK_W-1:0]    tick_cnt;
    logic [BIT_W-1:0]     bit_cnt;
    logic [DATA_BITS-1:0] shreg;

    uart_rx_sync u_sync (
        .clk_in  (clk_in),
        .nrst_in (nrst_in),
        .d       (rx_in),
        .q       (rxs)
    );

    always_ff @(posedge clk_in or negedge nrst_in) begin
        if (!nrst_in) begin
            state           <= IDLE;
            tick_cnt        <= '0;
            bit_cnt         <= '0;
            shreg           <= '0;
            data_out        <= '0;
            valid_out       <= 1'b0;
            busy_out        <= 1'b0;
            frame_err_out   <= 1'b0;
            overrun_err_out <= 1'b0;
        end else begin
            frame_err_out   <= 1'b0;
            overrun_err_out <= 1'b0;
            // NOTE: a delivery later in this block overrides this clear, because the
            // last non-blocking assignment to a flop within one edge is the one that lands.
            if (valid_out && ready_in)
                valid_out <= 1'b0;

            if (os_tick_in) begin
                case (state)
                    IDLE: begin
                        if (!rxs) begin
                            state    <= START;
                            tick_cnt <= '0;
                            busy_out <= 1'b1;
                        end
                    end

                    START: begin
                        if (tick_cnt == HALF_LAST) begin
                            if (rxs) begin
                                state    <= IDLE;
                                busy_out <= 1'b0;
                            end else begin
                                state    <= DATA;
                                tick_cnt <= '0;
                                bit_cnt  <= '0;
                            end
                        end else begin
                            tick_cnt <= tick_cnt + 1'b1;
                        end
                    end

                    DATA: begin
                        if (tick_cnt == BIT_LAST) begin
                            shreg    <= {rxs, shreg[DATA_BITS-1:1]};
                            tick_cnt <= '0;
                            bit_cnt  <= bit_cnt + 1'b1;
                            if (bit_cnt == LAST_BIT)
                                state <= STOP;
                        end else begin
                            tick_cnt <= tick_cnt + 1'b1;
                        end
                    end

                    STOP: begin
                        if (tick_cnt == BIT_LAST) begin
                            tick_cnt <= '0;
                            if (rxs) begin
                                state    <= IDLE;
                                busy_out <= 1'b0;
                                // A same-cycle handshake frees the register for the new word.
                                if (!valid_out || ready_in) begin
                                    data_out  <= shreg;
                                    valid_out <= 1'b1;
                                end else begin
                                    overrun_err_out <= 1'b1;
                                end
                            end else begin
                                frame_err_out <= 1'b1;
                                state         <= WAIT_HIGH;
                            end
                        end else begin
                            tick_cnt <= tick_cnt + 1'b1;
                        end
                    end

                    WAIT_HIGH: begin
                        if (rxs) begin
                            state    <= IDLE;
                            busy_out <= 1'b0;
                        end
                    end

                    default: begin
                        state    <= IDLE;
                        busy_out <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
